// File: rtl/uart_frame_loader.sv
// uart_frame_loader
//
// Assembles bytes from the UART receiver into framed writes to a 256-byte buffer.
// Frame layout: SYNC_BYTE, base address, length (1..255), payload, and a checksum byte
// when FRAME_CSUM_EN is defined. The checksum is the 8-bit sum of base, length and payload.
//
// Build option:
//   FRAME_CSUM_EN  defined   -> checksum byte expected after the payload, err_code 2 possible
//                  undefined -> frame completes on the last payload byte, no checksum logic
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   rx_data       received byte, stable while rx_flag is high
//   rx_flag       level flag, high while a completed byte is held; rising edge = new byte
//   rd_addr       buffer read address
//   rd_data       registered buffer read data (read-first on a same-address write)
//   frame_done    one-cycle pulse, frame accepted
//   frame_err     one-cycle pulse, frame aborted
//   err_code      0 none, 1 timeout, 2 checksum, 3 zero length; held until next done/err
//   busy          high while a frame is in progress
//   last_base     base address of the last good frame
//   last_len      length of the last good frame

module uart_frame_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] last_base,
  output logic [7:0] last_len
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  // Abort is registered on the edge where the counter would reach TIMEOUT_CYCLES.
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrTimeout = 2'd1;
  localparam logic [1:0] ErrZeroLen = 2'd3;
`ifdef FRAME_CSUM_EN
  localparam logic [1:0] ErrCsum    = 2'd2;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
`ifdef FRAME_CSUM_EN
    StData,
    StCsum
`else
    StData
`endif
  } state_e;

  state_e            state_q, state_d;
  logic              rx_flag_q;
  logic [7:0]        ptr_q, ptr_d;
  logic [7:0]        base_q, base_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        remaining_q, remaining_d;
`ifdef FRAME_CSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif
  logic [TimerW-1:0] timer_q, timer_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        last_base_q, last_base_d;
  logic [7:0]        last_len_q, last_len_d;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem_q [256];
  logic              mem_we;
  logic              byte_accept;

  assign byte_accept = rx_flag & ~rx_flag_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    base_d       = base_q;
    len_d        = len_q;
    remaining_d  = remaining_q;
`ifdef FRAME_CSUM_EN
    sum_d        = sum_q;
`endif
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    last_base_d  = last_base_q;
    last_len_d   = last_len_q;
    mem_we       = 1'b0;

    if (state_q == StIdle || byte_accept) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerW'(1);
    end

    if (state_q != StIdle && !byte_accept && timer_q == TimerLast) begin
      state_d     = StIdle;
      timer_d     = '0;
      frame_err_d = 1'b1;
      err_code_d  = ErrTimeout;
    end else if (byte_accept) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = StAddr;
          end
        end
        StAddr: begin
          base_d  = rx_data;
          ptr_d   = rx_data;
`ifdef FRAME_CSUM_EN
          sum_d   = rx_data;
`endif
          state_d = StLen;
        end
        StLen: begin
          if (rx_data == 8'd0) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            err_code_d  = ErrZeroLen;
          end else begin
            len_d       = rx_data;
            remaining_d = rx_data;
`ifdef FRAME_CSUM_EN
            sum_d       = sum_q + rx_data;
`endif
            state_d     = StData;
          end
        end
        StData: begin
          mem_we      = 1'b1;
          ptr_d       = ptr_q + 8'd1;
          remaining_d = remaining_q - 8'd1;
`ifdef FRAME_CSUM_EN
          sum_d       = sum_q + rx_data;
          if (remaining_q == 8'd1) begin
            state_d = StCsum;
          end
`else
          if (remaining_q == 8'd1) begin
            state_d      = StIdle;
            frame_done_d = 1'b1;
            err_code_d   = ErrNone;
            last_base_d  = base_q;
            last_len_d   = len_q;
          end
`endif
        end
`ifdef FRAME_CSUM_EN
        StCsum: begin
          state_d = StIdle;
          if (rx_data == sum_q) begin
            frame_done_d = 1'b1;
            err_code_d   = ErrNone;
            last_base_d  = base_q;
            last_len_d   = len_q;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ErrCsum;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      // Starts high so a flag already asserted at reset release is not taken as a new byte.
      rx_flag_q    <= 1'b1;
      ptr_q        <= '0;
      base_q       <= '0;
      len_q        <= '0;
      remaining_q  <= '0;
`ifdef FRAME_CSUM_EN
      sum_q        <= '0;
`endif
      timer_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ErrNone;
      last_base_q  <= '0;
      last_len_q   <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      rx_flag_q    <= rx_flag;
      ptr_q        <= ptr_d;
      base_q       <= base_d;
      len_q        <= len_d;
      remaining_q  <= remaining_d;
`ifdef FRAME_CSUM_EN
      sum_q        <= sum_d;
`endif
      timer_q      <= timer_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      last_base_q  <= last_base_d;
      last_len_q   <= last_len_d;
      // Non-blocking read sees the pre-write contents on a same-address write.
      rd_data_q    <= mem_q[rd_addr];
    end
  end

  // Buffer contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= rx_data;
    end
  end

  assign rd_data    = rd_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != StIdle);
  assign last_base  = last_base_q;
  assign last_len   = last_len_q;

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Consumes completed bytes from the UART receiver (8-bit data bus plus a level "byte complete" flag) and assembles them into framed write packets that load an on-chip 256-byte buffer. Each frame carries a sync byte, target base address, length, payload and (optionally) a checksum. Downstream logic reads the buffer through a synchronous read port and is notified by a one-cycle done/error pulse.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 2_000_000, max idle clk cycles between bytes inside a frame (~20 ms at 100 MHz)

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte; stable while rx_flag high
- rx_flag  in  1  level, high while a completed byte is held
- rd_addr  in  8  buffer read address
- rd_data  out  8  buffer read data, registered
- frame_done  out  1  one-cycle pulse, frame accepted
- frame_err  out  1  one-cycle pulse, frame aborted
- err_code  out  2  0 none, 1 timeout, 2 checksum, 3 zero length; held until next done/err
- busy  out  1  high when state != IDLE
- last_base  out  8  base address of last good frame
- last_len  out  8  length of last good frame

## Operation
- Byte strobe: rx_flag_q registered copy; byte accepted when rx_flag=1 and rx_flag_q=0. rx_flag_q resets to 1, so a flag already high at reset release is never accepted.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM.
  - IDLE: accepted byte == SYNC_BYTE -> ADDR; any other byte ignored.
  - ADDR: store byte as base and write pointer; sum <= byte -> LEN.
  - LEN: byte == 0 -> err_code 3, frame_err, IDLE. Else remaining <= byte; sum += byte -> DATA.
  - DATA: mem[ptr] <= byte; ptr <= ptr+1 (mod 256, FF wraps to 00); sum += byte; remaining -= 1. On last byte -> CSUM (macro on) or complete (macro off).
  - CSUM: byte == sum (8-bit mod-256 sum of ADDR, LEN, payload) -> complete; else err_code 2, frame_err, IDLE.
  - Complete: frame_done, err_code 0, last_base/last_len updated, IDLE.
- Payload is written to memory as received; a failed frame leaves its bytes in the buffer. last_base/last_len change only on frame_done.
- Timeout: counter cleared on every accepted byte and in IDLE; increments otherwise; reaching TIMEOUT_CYCLES -> err_code 1, frame_err, IDLE. Counter width fits TIMEOUT_CYCLES.
- A SYNC_BYTE value inside ADDR/LEN/DATA/CSUM is data, not a restart.

## Timing
- Byte accepted at edge k (first edge where rx_flag=1, rx_flag_q=0); memory write and state update occur at edge k.
- frame_done/frame_err high in cycle after edge k of the final (or offending) byte, exactly one cycle.
- Timeout pulse in cycle after counter reaches TIMEOUT_CYCLES.
- rd_data = mem[rd_addr] one cycle after rd_addr is presented. Read and write to same address same edge: rd_data returns old contents (read-first).
- Reset: FSM IDLE, counters 0, all outputs 0; memory contents not reset. Reset mid-frame discards the frame with no pulse.
- Throughput: one byte per rx_flag rising edge; no back-pressure.

## Configuration
- FRAME_CSUM_EN defined: CSUM state present; frame ends after checksum byte; err_code 2 possible.
- Undefined: CSUM state and sum logic removed; frame_done after last payload byte; err_code 2 never produced.

## Test plan
- Macro on, bytes A5 10 03 11 22 33 79 -> one frame_done, err_code 0, mem[10..12]=11,22,33, last_base=10, last_len=03.
- Same frame with checksum 00 -> frame_err, err_code 2, mem[10..12] still 11,22,33, last_base/last_len unchanged.
- Wrap: A5 FE 03 01 02 03 07 -> frame_done, mem[FE]=01, mem[FF]=02, mem[00]=03.
- TIMEOUT_CYCLES=1000: A5 10 then silence -> frame_err, err_code 1 at 1000 cycles after last byte, busy low; next valid frame accepted.
- Noise 00 FF 5A before A5, then A5 20 00 -> noise ignored, frame_err with err_code 3.
- Reset asserted mid-DATA with rx_flag held high, released while still high -> no byte accepted until next rising edge; no frame_done/frame_err pulse; busy 0.
